sa_result_drain: RTL and testbench

SA_RESULT_DRAIN -- requirements
Module: sa_result_drain

---
 rtl/sa_pkg.sv | 13 +
 rtl/sa_drain_fifo.sv | 56 +++++
 rtl/sa_result_drain.sv | 117 +++++++++++
 tb/tb_sa_result_drain.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array result drain: default word
// width and the drain-FSM state encoding.
package sa_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } drain_state_e;

endpackage

// File: rtl/sa_drain_fifo.sv
// Output FIFO for drained words: stores {last, data}, wrap-bit pointers,
// head presented combinationally (zeroed while empty), no write-to-read bypass.
module sa_drain_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  push_last,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  head_last,
    output logic                  full,
    output logic                  empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PW = AW + 1;

    logic [DATA_WIDTH:0] mem [DEPTH];
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [DATA_WIDTH:0] head_entry;
    logic                do_push;
    logic                do_pop;

    // Occupancy flags and head word decode
    always_comb begin
        empty      = (wr_ptr == rd_ptr);
        full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        do_push    = push && !full;
        do_pop     = pop && !empty;
        head_entry = mem[rd_ptr[AW-1:0]];
        head_data  = empty ? '0 : head_entry[DATA_WIDTH-1:0];
        head_last  = empty ? 1'b0 : head_entry[DATA_WIDTH];
    end

    // Pointer update; the extra wrap bit separates full from empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Storage write
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= {push_last, push_data};
    end

endmodule

// File: rtl/sa_result_drain.sv
// Drains CHAIN_LEN words out of the array's move-buffer chain into an
// output FIFO with a valid/ready interface. Optional stall statistics are
// enabled by defining SA_RESULT_DRAIN_STATS_EN.
module sa_result_drain
    import sa_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned CHAIN_LEN  = 8,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] chain_in,
    output logic                  shift_en,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
`ifdef SA_RESULT_DRAIN_STATS_EN
    ,
    output logic [15:0]           stall_cnt
`endif
);

    localparam int unsigned CNT_W = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CHAIN_LEN - 1);

    drain_state_e     state;
    drain_state_e     state_next;
    logic [CNT_W-1:0] word_cnt;
    logic             is_last;
    logic             fifo_full;
    logic             fifo_empty;

    assign is_last = (word_cnt == LAST_IDX);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (shift_en && is_last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode; shift_en follows FIFO space so a full FIFO stalls the chain
    always_comb begin
        shift_en = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            SHIFT: begin
                shift_en = !fifo_full;
                busy     = 1'b1;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // Word counter: cleared on accepted start, wraps to 0 after the last word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt <= '0;
        end else if (state == IDLE && start) begin
            word_cnt <= '0;
        end else if (shift_en) begin
            word_cnt <= is_last ? '0 : word_cnt + CNT_W'(1);
        end
    end

`ifdef SA_RESULT_DRAIN_STATS_EN
    // Saturating count of SHIFT cycles blocked by a full FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (state == IDLE && start) begin
            stall_cnt <= '0;
        end else if (state == SHIFT && fifo_full && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

    assign out_valid = !fifo_empty;

    sa_drain_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (shift_en),
        .push_data (chain_in),
        .push_last (is_last),
        .pop       (out_valid && out_ready),
        .head_data (out_data),
        .head_last (out_last),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_sa_result_drain.sv
// Self-checking bench for sa_result_drain (CHAIN_LEN=8, FIFO_DEPTH=4).
// A queue-based model predicts every output each cycle; scenario table
// checks per-run word/last/done totals. Honours SA_RESULT_DRAIN_STATS_EN.
module tb_sa_result_drain;

    localparam int unsigned DW = 32;
    localparam int unsigned CL = 8;
    localparam int unsigned FD = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [DW-1:0] chain_in;
    logic          shift_en;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          busy;
    logic          done;
`ifdef SA_RESULT_DRAIN_STATS_EN
    logic [15:0]   stall_cnt;
`endif

    always #5 clk = ~clk;

    sa_result_drain #(
        .DATA_WIDTH (DW),
        .CHAIN_LEN  (CL),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .chain_in  (chain_in),
        .shift_en  (shift_en),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
`ifdef SA_RESULT_DRAIN_STATS_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } word_t;

    typedef enum int {M_IDLE, M_SHIFT, M_DONE} mphase_e;

    typedef struct {
        string       name;
        logic [31:0] base;      // 0 selects a random base per run
        int          runs;
        int          mode;      // 0 ready=1, 1 toggle, 3 random
        bit          restart;   // pulse start again mid-run
        int          exp_words;
        int          exp_lasts;
        int          exp_dones;
    } scen_t;

    word_t       q[$];
    mphase_e     ph;
    int          m_cnt;
    logic [31:0] m_base;
    logic [31:0] next_base;
    int          m_stall;

    int checks   = 0;
    int failures = 0;
    int obs_words, obs_lasts, obs_dones, shift_hi;
    bit tog;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit rdy_fn(input int mode);
        if (mode == 1) begin
            tog = ~tog;
            return tog;
        end
        if (mode == 3) return 1'($urandom_range(0, 1));
        return 1'b1;
    endfunction

    task automatic model_reset();
        q.delete();
        ph      = M_IDLE;
        m_cnt   = 0;
        m_stall = 0;
    endtask

    // One clock: drive after the falling edge, compare, then advance the model
    task automatic cycle(input bit st, input bit rdy);
        logic [DW+4:0] exp_v, act_v;
        word_t         hd, w;
        bit            e_shift, e_valid;
        start     = st;
        out_ready = rdy;
        chain_in  = (ph == M_SHIFT) ? m_base + 32'(m_cnt) : 32'hDEAD_0000 + 32'(m_cnt);
        #1;
        e_shift = (ph == M_SHIFT) && (q.size() < FD);
        e_valid = (q.size() > 0);
        hd      = e_valid ? q[0] : '0;
        exp_v   = {e_shift, e_valid, hd.last, ph != M_IDLE, ph == M_DONE, hd.data};
        act_v   = {shift_en, out_valid, out_last, busy, done, out_data};
        check("cycle_outputs", 64'(act_v), 64'(exp_v));
`ifdef SA_RESULT_DRAIN_STATS_EN
        check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif
        if (shift_en) shift_hi++;
        if (out_valid && out_ready) begin
            obs_words++;
            if (out_last) obs_lasts++;
        end
        if (done) obs_dones++;
        @(posedge clk);
        case (ph)
            M_IDLE: if (st) begin
                ph      = M_SHIFT;
                m_cnt   = 0;
                m_base  = next_base;
                m_stall = 0;
            end
            M_SHIFT: if (q.size() == FD && m_stall < 65535) m_stall++;
            M_DONE:  ph = M_IDLE;
            default: ;
        endcase
        if (e_valid && rdy) void'(q.pop_front());
        if (e_shift) begin
            w.data = chain_in;
            w.last = (m_cnt == CL - 1);
            q.push_back(w);
            if (w.last) begin
                ph    = M_DONE;
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic clear_tallies();
        obs_words = 0;
        obs_lasts = 0;
        obs_dones = 0;
        shift_hi  = 0;
    endtask

    // Back-to-back runs followed by a full drain of the FIFO
    task automatic run_runs(input logic [31:0] base, input int runs, input int mode, input bit restart);
        for (int r = 0; r < runs; r++) begin
            next_base = (base != 0) ? base : ($urandom & 32'hFFFF_FF00);
            cycle(1'b1, rdy_fn(mode));
            for (int c = 0; c < 300 && ph != M_IDLE; c++)
                cycle(restart && ph == M_SHIFT && m_cnt == 3, rdy_fn(mode));
            check("run_timeout", 64'(ph == M_IDLE), 64'd1);
        end
        for (int c = 0; c < 300 && q.size() > 0; c++) cycle(1'b0, rdy_fn(mode));
        check("drain_timeout", 64'(q.size()), 64'd0);
    endtask

    task automatic check_all_zero(input string name);
        check(name, 64'({shift_en, out_valid, out_last, busy, done, out_data}), 64'd0);
`ifdef SA_RESULT_DRAIN_STATS_EN
        check({name, "_stall"}, 64'(stall_cnt), 64'd0);
`endif
    endtask

    scen_t tbl[5];

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{"basic_0x10",   32'h10, 1, 0, 1'b0,  8, 1, 1};
        tbl[1] = '{"toggle_x3",    32'h0,  3, 1, 1'b0, 24, 3, 3};
        tbl[2] = '{"restart_mid",  32'h0,  1, 0, 1'b1,  8, 1, 1};
        tbl[3] = '{"random_x4",    32'h0,  4, 3, 1'b0, 32, 4, 4};
        tbl[4] = '{"basic_again",  32'h10, 1, 0, 1'b0,  8, 1, 1};

        rst_n     = 1'b0;
        start     = 1'b0;
        out_ready = 1'b0;
        chain_in  = '0;
        tog       = 1'b0;
        next_base = 32'h0;
        model_reset();
        #3;
        check_all_zero("reset_state");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Scenario table
        foreach (tbl[i]) begin
            clear_tallies();
            run_runs(tbl[i].base, tbl[i].runs, tbl[i].mode, tbl[i].restart);
            check({tbl[i].name, "_words"}, 64'(obs_words), 64'(tbl[i].exp_words));
            check({tbl[i].name, "_lasts"}, 64'(obs_lasts), 64'(tbl[i].exp_lasts));
            check({tbl[i].name, "_dones"}, 64'(obs_dones), 64'(tbl[i].exp_dones));
        end

        // Backpressure: a 4-deep FIFO accepts exactly 4 words, then the run stalls
        clear_tallies();
        next_base = 32'h60;
        cycle(1'b1, 1'b0);
        shift_hi = 0;
        repeat (10) cycle(1'b0, 1'b0);
        check("bp_pushes_before_stall", 64'(shift_hi), 64'd4);
`ifdef SA_RESULT_DRAIN_STATS_EN
        check("bp_stall_nonzero", 64'(stall_cnt != 0), 64'd1);
`endif
        for (int c = 0; c < 100 && (ph != M_IDLE || q.size() > 0); c++) cycle(1'b0, 1'b1);
        check("bp_words", 64'(obs_words), 64'd8);
        check("bp_lasts", 64'(obs_lasts), 64'd1);

        // Reset after the third push, then a clean run
        next_base = 32'h30;
        cycle(1'b1, 1'b0);
        for (int c = 0; c < 20 && m_cnt < 3; c++) cycle(1'b0, 1'b0);
        check("pre_reset_pushes", 64'(m_cnt), 64'd3);
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_mid_run");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b0, 1'b1);
        clear_tallies();
        run_runs(32'h50, 1, 0, 1'b0);
        check("post_reset_words", 64'(obs_words), 64'd8);
        check("post_reset_dones", 64'(obs_dones), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
